timer_host: RTL and testbench

Bus-side initiator for the interval timer peripheral. It accepts timer commands on a valid/ready port and runs the matching register bus cycles: program count, prescale and IRQ enable; read the count; read status; wait for IRQ. Results return on a valid/ready response port. It sits between the CPU-side sequencer and the timer, in place of a full processor bus master.

---
 rtl/timer_host_pkg.sv | 34 +++
 rtl/timer_host.sv | 145 ++++++++++++++
 tb/tb_timer_host.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_host_pkg.sv
// Shared encodings for the interval timer host and the timer peripheral:
// command ops, host FSM states and register address constants.
package timer_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE       = 2'b00,
    OP_READ_TIMER  = 2'b01,
    OP_READ_STATUS = 2'b10,
    OP_WAIT_IRQ    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUS1,
    ST_BUS2,
    ST_GAP,
    ST_RESP
  } state_e;

  localparam logic [1:0] ADDR_TIMER  = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam int         IRQ_BIT     = 7;

  // WRITE folds the prescale select into the low address bits
  function automatic logic [2:0] cmd_addr(input op_e op, input logic irq_en,
                                          input logic [1:0] div);
    case (op)
      OP_WRITE:      return {irq_en, div};
      OP_READ_TIMER: return {irq_en, ADDR_TIMER};
      default:       return {irq_en, ADDR_STATUS};
    endcase
  endfunction

endpackage

// File: rtl/timer_host.sv
// Bus-side initiator for the interval timer: turns valid/ready commands into
// two-cycle register bus accesses and returns results on a response port.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// BUS1    | first bus cycle, bus_enable/addr/we_n/wdata driven
// BUS2    | second bus cycle, read data sampled on the edge leaving it
// GAP     | WAIT_IRQ idle time between polls, bus_enable low
// RESP    | response held on rsp_* until rsp_ready
module timer_host
  import timer_host_pkg::*;
#(
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT_POLLS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_div,
  input  logic       cmd_irq_en,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       bus_enable,
  output logic       bus_we_n,
  output logic [2:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_oe,
  input  logic       irq_n
);

  localparam logic [7:0] GAP_LOAD    = 8'(POLL_GAP - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_POLLS);

  state_e     state;
  op_e        op_q;
  logic [7:0] data_q;
  logic [7:0] poll_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] poll_next;
  logic       irq_seen;
  op_e        cmd_op_e;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign poll_next = poll_cnt + 8'd1;
  // a status read with bus_oe low carries no IRQ information
  assign irq_seen  = (bus_oe && bus_rdata[IRQ_BIT]) || !irq_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_WRITE;
      data_q     <= 8'h00;
      poll_cnt   <= 8'h00;
      gap_cnt    <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_err    <= 1'b0;
      bus_enable <= 1'b0;
      bus_we_n   <= 1'b1;
      bus_addr   <= 3'b000;
      bus_wdata  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op_e;
            data_q     <= cmd_data;
            poll_cnt   <= 8'h00;
            bus_enable <= 1'b1;
            bus_we_n   <= (cmd_op_e != OP_WRITE);
            bus_addr   <= cmd_addr(cmd_op_e, cmd_irq_en, cmd_div);
            if (cmd_op_e == OP_WRITE) bus_wdata <= cmd_data;
            state      <= ST_BUS1;
          end
        end

        ST_BUS1: state <= ST_BUS2;

        ST_BUS2: begin
          bus_enable <= 1'b0;
          bus_we_n   <= 1'b1;
          case (op_q)
            OP_WRITE: begin
              rsp_data  <= data_q;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
            OP_READ_TIMER, OP_READ_STATUS: begin
              rsp_data  <= bus_oe ? bus_rdata : 8'h00;
              rsp_err   <= !bus_oe;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
            default: begin
              poll_cnt <= poll_next;
              if (irq_seen) begin
                rsp_data  <= poll_next;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
              end else if (poll_next == TIMEOUT_CNT) begin
                rsp_data  <= TIMEOUT_CNT;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= ST_GAP;
              end
            end
          endcase
        end

        ST_GAP: begin
          // address and read strobe were held; only re-enable the bus
          if (gap_cnt == 8'h00) begin
            bus_enable <= 1'b1;
            state      <= ST_BUS1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_host.sv
// Self-checking bench for timer_host: scoreboarded responses plus bus
// timing checks for writes, reads, IRQ polling, backpressure and reset.
module tb_timer_host;
  import timer_host_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_div;
  logic       cmd_irq_en;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       bus_enable;
  logic       bus_we_n;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_oe;
  logic       irq_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rsp_t;
  rsp_t sb[$];

  timer_host #(.POLL_GAP(4), .TIMEOUT_POLLS(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_div(cmd_div), .cmd_irq_en(cmd_irq_en), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .bus_enable(bus_enable), .bus_we_n(bus_we_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_oe(bus_oe), .irq_n(irq_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // response scoreboard: compare at the cycle the handshake completes
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // call at a negedge; returns 1 time unit after the accepting edge
  task automatic send(input logic [1:0] op, input logic [1:0] div, input logic irq_en,
                      input logic [7:0] data, input bit push,
                      input logic [7:0] exp_data, input logic exp_err);
    int n = 0;
    rsp_t e;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_op = op; cmd_div = div; cmd_irq_en = irq_en; cmd_data = data;
    cmd_valid = 1'b1;
    if (push) begin
      e.data = exp_data;
      e.err  = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  // single bus access timing for the 4 cycles after acceptance
  task automatic check_bus(input logic [2:0] exp_addr, input logic exp_we_n,
                           input logic [7:0] exp_wdata);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("bus_enable", bus_enable, (k <= 2));
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_we_n", bus_we_n, (k <= 2) ? exp_we_n : 1'b1);
      if (k <= 2 && !exp_we_n) chk("bus_wdata", bus_wdata, exp_wdata);
      chk("rsp_valid", rsp_valid, (k == 3));
      chk("cmd_ready", cmd_ready, (k == 4));
    end
  endtask

  // mode 0: status bit 7 from poll 3, mode 1: irq_n low from poll 3, 2: never
  task automatic run_wait(input int mode, input logic irq_en, input int exp_polls,
                          input logic exp_err);
    int polls = 0;
    int en_len = 0;
    int gap = 0;
    bit prev_en = 1'b0;
    bit done = 1'b0;
    bus_rdata = 8'h00;
    bus_oe = 1'b1;
    irq_n = 1'b1;
    send(OP_WAIT_IRQ, 2'b00, irq_en, 8'h00, 1'b1, 8'(exp_polls), exp_err);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus_enable) begin
        if (!prev_en) begin
          polls++;
          if (polls > 1) chk("poll_gap", gap, 4);
          en_len = 0;
          if (mode == 0 && polls >= 3) bus_rdata = 8'h80;
          if (mode == 1 && polls >= 3) irq_n = 1'b0;
        end
        en_len++;
        chk("poll_addr", bus_addr, {irq_en, ADDR_STATUS});
        chk("poll_we_n", bus_we_n, 1'b1);
      end else begin
        if (prev_en) chk("poll_len", en_len, 2);
        gap = prev_en ? 1 : gap + 1;
      end
      prev_en = bus_enable;
      if (rsp_valid) done = 1'b1;
    end
    chk("wait_done", done, 1'b1);
    chk("poll_count", polls, exp_polls);
    @(negedge clk);
    bus_rdata = 8'h00;
    irq_n = 1'b1;
  endtask

  initial begin
    int a1;
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_div = 2'b00; cmd_irq_en = 1'b0;
    cmd_data = 8'h00; rsp_ready = 1'b1;
    bus_rdata = 8'h00; bus_oe = 1'b1; irq_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_bus_enable", bus_enable, 1'b0);
    chk("rst_bus_we_n", bus_we_n, 1'b1);
    chk("rst_bus_addr", bus_addr, 3'b000);
    chk("rst_bus_wdata", bus_wdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    send(OP_WRITE, 2'b10, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0);
    check_bus(3'b110, 1'b0, 8'h40);

    bus_rdata = 8'h3C; bus_oe = 1'b1;
    send(OP_READ_TIMER, 2'b11, 1'b0, 8'h99, 1'b1, 8'h3C, 1'b0);
    a1 = accept_cyc;
    check_bus(3'b000, 1'b1, 8'h00);

    bus_oe = 1'b0;
    send(OP_READ_TIMER, 2'b00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    chk("throughput", accept_cyc - a1, 4);
    check_bus(3'b000, 1'b1, 8'h00);

    bus_oe = 1'b1; bus_rdata = 8'h81;
    send(OP_READ_STATUS, 2'b10, 1'b1, 8'h00, 1'b1, 8'h81, 1'b0);
    check_bus(3'b101, 1'b1, 8'h00);

    run_wait(0, 1'b0, 3, 1'b0);
    run_wait(1, 1'b1, 3, 1'b0);
    run_wait(2, 1'b0, 5, 1'b1);

    // backpressure: response must hold while rsp_ready is low
    bus_oe = 1'b1; bus_rdata = 8'h5A;
    rsp_ready = 1'b0;
    send(OP_READ_TIMER, 2'b00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", rsp_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1'b1);
      chk("stall_rsp_data", rsp_data, 8'h5A);
      chk("stall_rsp_err", rsp_err, 1'b0);
      chk("stall_cmd_ready", cmd_ready, 1'b0);
      chk("stall_bus_enable", bus_enable, 1'b0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release", cmd_ready, 1'b1);

    // asynchronous reset in BUS1 of a read: no response may appear
    bus_rdata = 8'h77;
    send(OP_READ_TIMER, 2'b00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_bus_enable", bus_enable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bus_enable", bus_enable, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_bus_addr", bus_addr, 3'b000);
    chk("mid_rst_bus_we_n", bus_we_n, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(OP_WRITE, 2'b01, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0);
    check_bus(3'b001, 1'b0, 8'hA5);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
